npc_bpu: RTL and testbench

Fetch-stage next-PC predictor for the pipelined MIPS CPU. It generalises ID-stage next-PC selection into a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and a return-address stack (RAS), all parametrised. The block predicts the fetch NPC in IF, trains from outcomes resolved in ID, and flags mispredictions with a redirect PC. This generation has no architectural delay slot: the fall-through PC is PC+4.

---
 rtl/npc_bpu.sv | 271 +++++++++++++++++++++++++++
 tb/tb_npc_bpu.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/npc_bpu.sv
// ---------------------------------------------------------------------------
// npc_bpu - fetch-stage next-PC predictor
//
// Predicts the next fetch PC from a direct-mapped branch target buffer (BTB)
// with 2-bit saturating counters and a return-address stack (RAS). Training
// and RAS updates happen when a control-flow instruction is resolved in ID,
// so the RAS is non-speculative. There is no delay slot: fall-through is PC+4.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   PCF               current fetch PC
//   PredNPCF          predicted next fetch PC (combinational from PCF)
//   PredTakenF        prediction differs from PCF+4
//   ResValidD         one resolved control-flow instruction this cycle
//   ResPCD            PC of the resolved instruction
//   ResIsBrD          conditional branch
//   ResIsJD           any jump (j/jal/jr/jalr)
//   ResIsCallD        jal/jalr (pushes the return address)
//   ResIsRetD         jr $31 (pops the return address)
//   ResTakenD         actual direction (1 for jumps)
//   ResTargetD        actual taken target
//   ResPredNPCD       prediction that was made for this instruction in IF
//   MispredD          prediction was wrong
//   RedirectPCD       correct next PC (0 when ResValidD is low)
// ---------------------------------------------------------------------------
module npc_bpu #(
    parameter int          ADDR_W    = 32,
    parameter int          ENTRIES   = 16,
    parameter int          RAS_DEPTH = 4,
    parameter logic [1:0]  CNT_INIT  = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PCF,
    output logic [ADDR_W-1:0] PredNPCF,
    output logic              PredTakenF,
    input  logic              ResValidD,
    input  logic [ADDR_W-1:0] ResPCD,
    input  logic              ResIsBrD,
    input  logic              ResIsJD,
    input  logic              ResIsCallD,
    input  logic              ResIsRetD,
    input  logic              ResTakenD,
    input  logic [ADDR_W-1:0] ResTargetD,
    input  logic [ADDR_W-1:0] ResPredNPCD,
    output logic              MispredD,
    output logic [ADDR_W-1:0] RedirectPCD
);

    localparam int IDX_W  = $clog2(ENTRIES);
    localparam int TAG_W  = ADDR_W - IDX_W - 2;
    localparam int RAS_PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int RAS_CW = $clog2(RAS_DEPTH + 1);

    typedef enum logic [1:0] {
        TYPE_BR  = 2'd0,
        TYPE_JMP = 2'd1,
        TYPE_RET = 2'd2
    } btb_type_e;

    // Combinational views of the per-entry BTB registers.
    logic [ENTRIES-1:0]             btb_valid;
    logic [ENTRIES-1:0][TAG_W-1:0]  btb_tag;
    logic [ENTRIES-1:0][ADDR_W-1:0] btb_target;
    logic [ENTRIES-1:0][1:0]        btb_type;
    logic [ENTRIES-1:0][1:0]        btb_cnt;

    // Single BTB write port, driven by resolution.
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_valid;
    logic [TAG_W-1:0]  wr_tag;
    logic [ADDR_W-1:0] wr_target;
    logic [1:0]        wr_type;
    logic [1:0]        wr_cnt;

    // RAS state.
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
    logic [RAS_PW-1:0] ras_top_q, ras_top_d;
    logic [RAS_CW-1:0] ras_cnt_q, ras_cnt_d;

    // PC[1:0] is always zero and carries no information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PCF[1:0], ResPCD[1:0]};

    // -----------------------------------------------------------------------
    // BTB entries: one register set per entry with a decoded write enable.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_btb
            logic              sel;
            logic              valid_q,  valid_d;
            logic [TAG_W-1:0]  tag_q,    tag_d;
            logic [ADDR_W-1:0] target_q, target_d;
            logic [1:0]        type_q,   type_d;
            logic [1:0]        cnt_q,    cnt_d;

            always_comb begin
                sel      = wr_en && (wr_idx == IDX_W'(gi));
                valid_d  = sel ? wr_valid  : valid_q;
                tag_d    = sel ? wr_tag    : tag_q;
                target_d = sel ? wr_target : target_q;
                type_d   = sel ? wr_type   : type_q;
                cnt_d    = sel ? wr_cnt    : cnt_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q  <= 1'b0;
                    tag_q    <= '0;
                    target_q <= '0;
                    type_q   <= TYPE_BR;
                    cnt_q    <= CNT_INIT;
                end else begin
                    valid_q  <= valid_d;
                    tag_q    <= tag_d;
                    target_q <= target_d;
                    type_q   <= type_d;
                    cnt_q    <= cnt_d;
                end
            end

            assign btb_valid[gi]  = valid_q;
            assign btb_tag[gi]    = tag_q;
            assign btb_target[gi] = target_q;
            assign btb_type[gi]   = type_q;
            assign btb_cnt[gi]    = cnt_q;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Fetch lookup (combinational, sees pre-edge contents).
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0]  f_idx;
    logic [TAG_W-1:0]  f_tag;
    logic              f_hit;
    logic [ADDR_W-1:0] f_pc_plus4;
    logic [ADDR_W-1:0] f_pred;

    always_comb begin
        f_idx      = PCF[IDX_W+1:2];
        f_tag      = PCF[ADDR_W-1:IDX_W+2];
        f_pc_plus4 = PCF + ADDR_W'(4);
        f_hit      = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
        f_pred     = f_pc_plus4;
        if (f_hit) begin
            case (btb_type[f_idx])
                TYPE_RET: f_pred = (ras_cnt_q != '0) ? ras_q[ras_top_q]
                                                     : btb_target[f_idx];
                TYPE_JMP: f_pred = btb_target[f_idx];
                TYPE_BR:  if (btb_cnt[f_idx][1]) f_pred = btb_target[f_idx];
                default:  f_pred = f_pc_plus4;
            endcase
        end
    end

    assign PredNPCF   = f_pred;
    assign PredTakenF = (f_pred != f_pc_plus4);

    // -----------------------------------------------------------------------
    // Resolution: misprediction check and redirect.
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] res_pc_plus4;
    logic [ADDR_W-1:0] actual_npc;

    always_comb begin
        res_pc_plus4 = ResPCD + ADDR_W'(4);
        actual_npc   = ResTakenD ? ResTargetD : res_pc_plus4;
        MispredD     = ResValidD && (actual_npc != ResPredNPCD);
        RedirectPCD  = ResValidD ? actual_npc : '0;
    end

    // -----------------------------------------------------------------------
    // BTB training.
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0]  res_idx;
    logic [TAG_W-1:0]  res_tag;
    logic              res_hit;
    logic [1:0]        cur_cnt;
    logic [1:0]        cnt_inc;
    logic [1:0]        cnt_dec;

    always_comb begin
        res_idx = ResPCD[IDX_W+1:2];
        res_tag = ResPCD[ADDR_W-1:IDX_W+2];
        res_hit = btb_valid[res_idx] && (btb_tag[res_idx] == res_tag);
        cur_cnt = btb_cnt[res_idx];
        cnt_inc = (cur_cnt == 2'b11) ? 2'b11 : cur_cnt + 2'd1;
        cnt_dec = (cur_cnt == 2'b00) ? 2'b00 : cur_cnt - 2'd1;

        wr_en     = 1'b0;
        wr_idx    = res_idx;
        wr_valid  = btb_valid[res_idx];
        wr_tag    = btb_tag[res_idx];
        wr_target = btb_target[res_idx];
        wr_type   = btb_type[res_idx];
        wr_cnt    = cur_cnt;

        if (ResValidD) begin
            if (ResIsJD) begin
                // Jumps always (re)write; a fresh allocation starts weakly taken.
                wr_en     = 1'b1;
                wr_valid  = 1'b1;
                wr_tag    = res_tag;
                wr_target = ResTargetD;
                wr_type   = ResIsRetD ? TYPE_RET : TYPE_JMP;
                wr_cnt    = res_hit ? cur_cnt : 2'b10;
            end else if (ResIsBrD) begin
                if (res_hit) begin
                    wr_en  = 1'b1;
                    wr_cnt = ResTakenD ? cnt_inc : cnt_dec;
                    if (ResTakenD) wr_target = ResTargetD;
                end else if (ResTakenD) begin
                    // Only taken branches are worth a BTB slot.
                    wr_en     = 1'b1;
                    wr_valid  = 1'b1;
                    wr_tag    = res_tag;
                    wr_target = ResTargetD;
                    wr_type   = TYPE_BR;
                    wr_cnt    = 2'b10;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Return-address stack: circular buffer, top pointer plus occupancy.
    // Overflow silently overwrites the oldest entry.
    // -----------------------------------------------------------------------
    logic [RAS_PW-1:0] top_inc;
    logic [RAS_PW-1:0] top_dec;

    always_comb begin
        top_inc = (ras_top_q == RAS_PW'(RAS_DEPTH - 1)) ? '0 : ras_top_q + RAS_PW'(1);
        top_dec = (ras_top_q == '0) ? RAS_PW'(RAS_DEPTH - 1) : ras_top_q - RAS_PW'(1);

        ras_d     = ras_q;
        ras_top_d = ras_top_q;
        ras_cnt_d = ras_cnt_q;

        if (ResValidD) begin
            if (ResIsCallD && ResIsRetD) begin
                // jalr $31: pop then push collapses into replacing the top.
                ras_d[ras_top_q] = res_pc_plus4;
                if (ras_cnt_q == '0) ras_cnt_d = RAS_CW'(1);
            end else if (ResIsCallD) begin
                ras_top_d      = top_inc;
                ras_d[top_inc] = res_pc_plus4;
                if (ras_cnt_q != RAS_CW'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + RAS_CW'(1);
            end else if (ResIsRetD && (ras_cnt_q != '0)) begin
                ras_top_d = top_dec;
                ras_cnt_d = ras_cnt_q - RAS_CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
            ras_top_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_q     <= ras_d;
            ras_top_q <= ras_top_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

endmodule

// File: tb/tb_npc_bpu.sv
module tb_npc_bpu;

    logic        clk;
    logic        rst;
    logic [31:0] PCF;
    logic [31:0] PredNPCF;
    logic        PredTakenF;
    logic        ResValidD;
    logic [31:0] ResPCD;
    logic        ResIsBrD, ResIsJD, ResIsCallD, ResIsRetD, ResTakenD;
    logic [31:0] ResTargetD;
    logic [31:0] ResPredNPCD;
    logic        MispredD;
    logic [31:0] RedirectPCD;

    npc_bpu #(
        .ADDR_W(32), .ENTRIES(16), .RAS_DEPTH(4), .CNT_INIT(2'b01)
    ) dut (
        .clk(clk), .rst(rst), .PCF(PCF),
        .PredNPCF(PredNPCF), .PredTakenF(PredTakenF),
        .ResValidD(ResValidD), .ResPCD(ResPCD),
        .ResIsBrD(ResIsBrD), .ResIsJD(ResIsJD),
        .ResIsCallD(ResIsCallD), .ResIsRetD(ResIsRetD),
        .ResTakenD(ResTakenD), .ResTargetD(ResTargetD),
        .ResPredNPCD(ResPredNPCD),
        .MispredD(MispredD), .RedirectPCD(RedirectPCD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {br, j, call, ret}
    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_BR   = 4'b1000;
    localparam logic [3:0] F_CALL = 4'b0110;
    localparam logic [3:0] F_RET  = 4'b0101;
    localparam logic [3:0] F_CR   = 4'b0111;

    typedef struct {
        logic [31:0] pcf;
        logic [31:0] e_npc;
        logic        e_tk;
        logic        rv;
        logic [3:0]  flags;
        logic        taken;
        logic [31:0] rpc;
        logic [31:0] tgt;
        logic [31:0] rpred;
        logic        e_mis;
        logic [31:0] e_redir;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic vec_t mk(input logic [31:0] pcf, input logic [31:0] e_npc,
                                input logic e_tk, input logic rv, input logic [3:0] flags,
                                input logic taken, input logic [31:0] rpc,
                                input logic [31:0] tgt, input logic [31:0] rpred,
                                input logic e_mis, input logic [31:0] e_redir);
        vec_t v;
        v.pcf = pcf; v.e_npc = e_npc; v.e_tk = e_tk; v.rv = rv; v.flags = flags;
        v.taken = taken; v.rpc = rpc; v.tgt = tgt; v.rpred = rpred;
        v.e_mis = e_mis; v.e_redir = e_redir;
        return v;
    endfunction

    function automatic vec_t lk(input logic [31:0] pcf, input logic [31:0] e_npc,
                                input logic e_tk);
        return mk(pcf, e_npc, e_tk, 1'b0, F_NONE, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic drive_res(input logic rv, input logic [3:0] flags, input logic taken,
                             input logic [31:0] rpc, input logic [31:0] tgt,
                             input logic [31:0] rpred);
        ResValidD   = rv;
        ResIsBrD    = flags[3];
        ResIsJD     = flags[2];
        ResIsCallD  = flags[1];
        ResIsRetD   = flags[0];
        ResTakenD   = taken;
        ResPCD      = rpc;
        ResTargetD  = tgt;
        ResPredNPCD = rpred;
    endtask

    initial begin
        rst = 1'b1;
        PCF = 32'h0;
        drive_res(1'b0, F_NONE, 1'b0, 32'h0, 32'h0, 32'h0);

        // Branch training and counter hysteresis.
        vecs.push_back(lk(32'h00400000, 32'h00400004, 1'b0));
        vecs.push_back(mk(32'h00400010, 32'h00400014, 1'b0, 1'b1, F_BR, 1'b1, 32'h00400010, 32'h00400100, 32'h00400014, 1'b1, 32'h00400100));
        vecs.push_back(lk(32'h00400010, 32'h00400100, 1'b1));
        vecs.push_back(mk(32'h00400050, 32'h00400054, 1'b0, 1'b1, F_BR, 1'b0, 32'h00400010, 32'h00400100, 32'h00400100, 1'b1, 32'h00400014));
        vecs.push_back(mk(32'h00400010, 32'h00400014, 1'b0, 1'b1, F_BR, 1'b1, 32'h00400010, 32'h00400100, 32'h00400014, 1'b1, 32'h00400100));
        vecs.push_back(mk(32'h00400010, 32'h00400100, 1'b1, 1'b1, F_BR, 1'b1, 32'h00400010, 32'h00400100, 32'h00400100, 1'b0, 32'h00400100));
        vecs.push_back(mk(32'h00400010, 32'h00400100, 1'b1, 1'b1, F_BR, 1'b1, 32'h00400010, 32'h00400100, 32'h00400100, 1'b0, 32'h00400100));
        vecs.push_back(mk(32'h00400010, 32'h00400100, 1'b1, 1'b1, F_BR, 1'b0, 32'h00400010, 32'h00400100, 32'h00400100, 1'b1, 32'h00400014));
        vecs.push_back(mk(32'h00400010, 32'h00400100, 1'b1, 1'b1, F_BR, 1'b0, 32'h00400010, 32'h00400100, 32'h00400100, 1'b1, 32'h00400014));
        vecs.push_back(lk(32'h00400010, 32'h00400014, 1'b0));
        // Call / return.
        vecs.push_back(mk(32'h00400000, 32'h00400004, 1'b0, 1'b1, F_RET,  1'b1, 32'h00400204, 32'h00400800, 32'h00400208, 1'b1, 32'h00400800));
        vecs.push_back(mk(32'h00400204, 32'h00400800, 1'b1, 1'b1, F_CALL, 1'b1, 32'h00400020, 32'h00400200, 32'h00400024, 1'b1, 32'h00400200));
        vecs.push_back(mk(32'h00400204, 32'h00400024, 1'b1, 1'b1, F_RET,  1'b1, 32'h00400204, 32'h00400024, 32'h00400024, 1'b0, 32'h00400024));
        // RAS overflow: five calls into a four-deep stack.
        vecs.push_back(mk(32'h00400204, 32'h00400024, 1'b1, 1'b1, F_CALL, 1'b1, 32'h00000100, 32'h00400200, 32'h00400200, 1'b0, 32'h00400200));
        vecs.push_back(mk(32'h00400204, 32'h00000104, 1'b1, 1'b1, F_CALL, 1'b1, 32'h00000200, 32'h00400200, 32'h00400200, 1'b0, 32'h00400200));
        vecs.push_back(mk(32'h00400204, 32'h00000204, 1'b1, 1'b1, F_CALL, 1'b1, 32'h00000300, 32'h00400200, 32'h00400200, 1'b0, 32'h00400200));
        vecs.push_back(mk(32'h00400204, 32'h00000304, 1'b1, 1'b1, F_CALL, 1'b1, 32'h00000400, 32'h00400200, 32'h00400200, 1'b0, 32'h00400200));
        vecs.push_back(mk(32'h00400204, 32'h00000404, 1'b1, 1'b1, F_CALL, 1'b1, 32'h00000500, 32'h00400200, 32'h00400200, 1'b0, 32'h00400200));
        vecs.push_back(mk(32'h00400204, 32'h00000504, 1'b1, 1'b1, F_RET,  1'b1, 32'h00400204, 32'h00000504, 32'h00000504, 1'b0, 32'h00000504));
        vecs.push_back(mk(32'h00400204, 32'h00000404, 1'b1, 1'b1, F_RET,  1'b1, 32'h00400204, 32'h00000404, 32'h00000404, 1'b0, 32'h00000404));
        vecs.push_back(mk(32'h00400204, 32'h00000304, 1'b1, 1'b1, F_RET,  1'b1, 32'h00400204, 32'h00000304, 32'h00000304, 1'b0, 32'h00000304));
        vecs.push_back(mk(32'h00400204, 32'h00000204, 1'b1, 1'b1, F_RET,  1'b1, 32'h00400204, 32'h00000204, 32'h00000204, 1'b0, 32'h00000204));
        vecs.push_back(mk(32'h00400204, 32'h00000204, 1'b1, 1'b1, F_RET,  1'b1, 32'h00400204, 32'h00400800, 32'h00000204, 1'b1, 32'h00400800));
        // Empty stack falls back to BTB target; ResValidD=0 with junk fields does nothing.
        vecs.push_back(mk(32'h00400204, 32'h00400800, 1'b1, 1'b0, F_BR,   1'b1, 32'h00400010, 32'h12345678, 32'h00000000, 1'b0, 32'h00000000));
        // jalr $31 on empty stack, then on a two-deep stack.
        vecs.push_back(mk(32'h00400010, 32'h00400014, 1'b0, 1'b1, F_CR,   1'b1, 32'h00400300, 32'h00400900, 32'h00400900, 1'b0, 32'h00400900));
        vecs.push_back(mk(32'h00400204, 32'h00400304, 1'b1, 1'b1, F_CALL, 1'b1, 32'h00000600, 32'h00400200, 32'h00400200, 1'b0, 32'h00400200));
        vecs.push_back(mk(32'h00400204, 32'h00000604, 1'b1, 1'b1, F_CR,   1'b1, 32'h00400300, 32'h00400900, 32'h00000604, 1'b1, 32'h00400900));
        vecs.push_back(mk(32'h00400204, 32'h00400304, 1'b1, 1'b1, F_RET,  1'b1, 32'h00400204, 32'h00400a00, 32'h00400304, 1'b1, 32'h00400a00));
        vecs.push_back(lk(32'h00400204, 32'h00400304, 1'b1));

        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            PCF = vecs[i].pcf;
            drive_res(vecs[i].rv, vecs[i].flags, vecs[i].taken, vecs[i].rpc,
                      vecs[i].tgt, vecs[i].rpred);
            #1;
            $display("vec %0d pcf=%h npc=%h tk=%b mis=%b redir=%h",
                     i, PCF, PredNPCF, PredTakenF, MispredD, RedirectPCD);
            chk($sformatf("v%0d_npc", i),   PredNPCF,             vecs[i].e_npc);
            chk($sformatf("v%0d_tk", i),    {31'b0, PredTakenF},  {31'b0, vecs[i].e_tk});
            chk($sformatf("v%0d_mis", i),   {31'b0, MispredD},    {31'b0, vecs[i].e_mis});
            chk($sformatf("v%0d_redir", i), RedirectPCD,          vecs[i].e_redir);
            @(negedge clk);
        end

        // Asynchronous reset mid-cycle clears the BTB without a clock edge.
        drive_res(1'b0, F_NONE, 1'b0, 32'h0, 32'h0, 32'h0);
        PCF = 32'h00400204;
        #2 rst = 1'b1;
        #1;
        $display("async rst pcf=%h npc=%h tk=%b", PCF, PredNPCF, PredTakenF);
        chk("arst_ret_npc", PredNPCF, 32'h00400208);
        chk("arst_ret_tk", {31'b0, PredTakenF}, 32'h0);
        PCF = 32'h00400010;
        #1;
        $display("async rst pcf=%h npc=%h tk=%b", PCF, PredNPCF, PredTakenF);
        chk("arst_br_npc", PredNPCF, 32'h00400014);
        @(negedge clk);
        rst = 1'b0;

        // A resolution in the same cycle as reset must be discarded.
        PCF = 32'h00400000;
        drive_res(1'b1, F_BR, 1'b1, 32'h00400040, 32'h00400abc, 32'h00400044);
        #1;
        $display("pre-rst res mis=%b redir=%h", MispredD, RedirectPCD);
        chk("rstdrop_mis", {31'b0, MispredD}, 32'h1);
        chk("rstdrop_redir", RedirectPCD, 32'h00400abc);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive_res(1'b0, F_NONE, 1'b0, 32'h0, 32'h0, 32'h0);
        PCF = 32'h00400040;
        #1;
        $display("post-rst pcf=%h npc=%h tk=%b mis=%b redir=%h",
                 PCF, PredNPCF, PredTakenF, MispredD, RedirectPCD);
        chk("rstdrop_npc", PredNPCF, 32'h00400044);
        chk("rstdrop_tk", {31'b0, PredTakenF}, 32'h0);
        chk("idle_mis", {31'b0, MispredD}, 32'h0);
        chk("idle_redir", RedirectPCD, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
